// File: rtl/motorb_vec_pack_config7.sv
// Purpose: serial-to-parallel packer, N_LANES words per vector, s_last framing check.
// Latency: m_valid rises 1 cycle after the N_LANES-th accepted word.
// Backpressure: s_ready low while a vector is held; vector stays until m_ready.
module motorb_vec_pack_config7 #(
    parameter int N_LANES = 9,
    parameter int DATA_W  = 32
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        s_last,
    output logic [N_LANES*DATA_W-1:0]   m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        err_len
);
    localparam int CW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_LANES - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_d;
    logic              xfer;
    logic [DATA_W-1:0] lane_q [N_LANES];

    // Gated by reset so upstream never sees a ready while the block is held in reset.
    assign s_ready = (state_q == FILL) && ap_rst_n;
    assign m_valid = (state_q == HOLD);
    assign xfer    = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            FILL: begin
                if (xfer) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        err_d   = !s_last;
                    end else if (s_last) begin
                        // Short frame: drop the partial vector and restart at lane 0.
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            err_len <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_len <= err_d;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int k = 0; k < N_LANES; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_LANES; k++) begin
                if (xfer && (cnt_q == CW'(k))) begin
                    lane_q[k] <= s_data;
                end
            end
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_pack
        assign m_data[g*DATA_W +: DATA_W] = lane_q[g];
    end

endmodule

// File: tb/tb_motorb_vec_pack_config7.sv
// Scoreboard bench for motorb_vec_pack_config7: directed frames push expected vectors,
// a negedge monitor compares every presented vector and counts err_len pulses.
module tb_motorb_vec_pack_config7;
    localparam int N  = 9;
    localparam int W  = 32;
    localparam int VW = N * W;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_last = 1'b0;
    logic [VW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          err_len;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_exp = 0;
    int vec_seen = 0;
    logic [VW-1:0] exp_q [$];

    motorb_vec_pack_config7 #(.N_LANES(N), .DATA_W(W)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_last   (s_last),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .err_len  (err_len)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare the presented vector every cycle it is valid, pop on handshake.
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            if (err_len) err_seen++;
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_vector: got %h expected none", m_data);
                end else begin
                    chk("vector_data", m_data, exp_q[0]);
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        vec_seen++;
                    end
                end
            end
        end
    end

    // Sends n words base+step*k; s_last on the final word if last=1; random idle gaps up to maxgap.
    task automatic send_frame(input logic [W-1:0] base, input logic [W-1:0] step,
                              input int n, input bit last, input int maxgap);
        logic [VW-1:0] v;
        bit ok;
        v = '0;
        for (int k = 0; k < n; k++) v[k*W +: W] = base + step * W'(k);
        if (n == N) exp_q.push_back(v);
        if ((n == N && !last) || (n < N && last)) err_exp++;
        for (int k = 0; k < n; k++) begin
            if (maxgap > 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, maxgap)) @(posedge ap_clk);
                #1;
            end
            s_data  = base + step * W'(k);
            s_last  = last && (k == n - 1);
            s_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge ap_clk);
                ok = s_ready;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL s_ready_timeout: got 0 expected 1");
            end
            @(posedge ap_clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("rst_m_valid", VW'(m_valid), '0);
        chk("rst_m_data", m_data, '0);
        chk("rst_s_ready", VW'(s_ready), '0);
        chk("rst_err_len", VW'(err_len), '0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        int e0;
        logic [VW-1:0] held;
        #2;
        do_reset();

        // 1 nominal
        e0 = err_seen;
        send_frame(32'h0000_0000, 32'h0000_0100, N, 1'b1, 0);
        @(negedge ap_clk);
        chk("nom_latency_m_valid", VW'(m_valid), VW'(1));
        @(negedge ap_clk);
        chk("nom_m_valid_one_cycle", VW'(m_valid), '0);
        chk("nom_no_err", VW'(err_seen - e0), '0);
        @(posedge ap_clk); #1;

        // 2 backpressure
        m_ready = 1'b0;
        send_frame(32'h0000_0000, 32'h0000_0100, N, 1'b1, 0);
        @(negedge ap_clk);
        held = m_data;
        for (int c = 0; c < 5; c++) begin
            chk("bp_m_valid", VW'(m_valid), VW'(1));
            chk("bp_s_ready", VW'(s_ready), '0);
            chk("bp_stable", m_data, held);
            @(negedge ap_clk);
        end
        @(posedge ap_clk); #1;
        m_ready = 1'b1;
        @(negedge ap_clk);
        chk("bp_s_ready_before_hs", VW'(s_ready), '0);
        @(negedge ap_clk);
        chk("bp_s_ready_after_hs", VW'(s_ready), VW'(1));
        chk("bp_m_valid_after_hs", VW'(m_valid), '0);
        @(posedge ap_clk); #1;

        // 3 short frame then full frame
        e0 = err_seen;
        send_frame(32'h1111_0000, 32'h1, 4, 1'b1, 0);
        @(negedge ap_clk);
        chk("short_err_pulse", VW'(err_len), VW'(1));
        chk("short_no_m_valid", VW'(m_valid), '0);
        @(negedge ap_clk);
        chk("short_err_one_cycle", VW'(err_len), '0);
        @(posedge ap_clk); #1;
        send_frame(32'hFFFF_FF00, 32'h1, N, 1'b1, 0);
        repeat (2) @(negedge ap_clk);
        chk("short_err_count", VW'(err_seen - e0), VW'(1));
        @(posedge ap_clk); #1;

        // 4 missing last
        e0 = err_seen;
        send_frame(32'hA5A5_0000, 32'h0001_0001, N, 1'b0, 0);
        @(negedge ap_clk);
        chk("miss_err_with_hold", {VW'(err_len), VW'(m_valid)} , {VW'(1), VW'(1)});
        repeat (2) @(negedge ap_clk);
        chk("miss_err_count", VW'(err_seen - e0), VW'(1));
        @(posedge ap_clk); #1;

        // 5 gapped input, three frames
        e0 = vec_seen;
        send_frame(32'h8000_0000, 32'h0000_0011, N, 1'b1, 2);
        send_frame(32'h7FFF_FFF0, 32'h0000_0001, N, 1'b1, 2);
        send_frame(32'h0123_4567, 32'h1000_0000, N, 1'b1, 2);
        repeat (3) @(negedge ap_clk);
        chk("gap_vector_count", VW'(vec_seen - e0), VW'(3));
        @(posedge ap_clk); #1;

        // 6 reset mid-frame, then reset in HOLD
        send_frame(32'hDEAD_0000, 32'h1, 5, 1'b0, 0);
        do_reset();
        send_frame(32'h0000_1000, 32'h0000_0010, N, 1'b1, 0);
        repeat (2) @(negedge ap_clk);
        @(posedge ap_clk); #1;
        m_ready = 1'b0;
        send_frame(32'hBEEF_0000, 32'h1, N, 1'b1, 0);
        @(negedge ap_clk);
        chk("hold_before_reset", VW'(m_valid), VW'(1));
        #1;
        do_reset();
        m_ready = 1'b1;
        send_frame(32'h0000_2000, 32'h0000_0020, N, 1'b1, 0);
        repeat (3) @(negedge ap_clk);

        chk("scoreboard_empty", VW'(exp_q.size()), '0);
        chk("err_total", VW'(err_seen), VW'(err_exp));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
